mem_bus_ctrl: RTL and testbench

// - Downstream of the CPU core: takes CPU memory requests (address, write data, write enable) and runs them on external async SRAM.
// - Inserts a programmable number of wait states, captures read data into DOUT, signals completion with a one-cycle RDY pulse.
// - Replaces the direct CPU-to-MEMORY hookup, so slow off-chip RAM/ROM can serve the CPU.

---
 rtl/mem_bus_pkg.sv | 14 +
 rtl/mem_wait_cnt.sv | 19 +
 rtl/mem_bus_ctrl.sv | 102 ++++++++++
 tb/tb_mem_bus_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared state encoding, default sizes and wait-count helpers for mem_bus_ctrl
package mem_bus_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, DONE = 2'd3} state_t;
  localparam int AW_DEF = 16;
  localparam int DW_DEF = 8;
  localparam int WAIT_DEF = 2;
  function automatic int wait_eff(input int w);
    return w < 1 ? 1 : w;
  endfunction
  function automatic int wait_w(input int w);
    return $clog2(wait_eff(w) + 1);
  endfunction
  localparam int WAIT_W = wait_w(WAIT_DEF);
endpackage

// File: rtl/mem_wait_cnt.sv
// mem_wait_cnt: loadable wait-state down-counter; zero marks the cycle whose closing edge empties it
module mem_wait_cnt #(
  parameter int W = 2
) (
  input  logic         CLK,
  input  logic         R,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;
  // load wins, otherwise count down and park at zero
  always_comb cnt_d = load ? value : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
  // count register
  always_ff @(posedge CLK)
    if (R) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero = cnt_q <= W'(1);
endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: CPU-to-async-SRAM bus controller with wait states; MEM_ROM_PROTECT_EN blocks writes at/above ROM_BASE
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int WAIT_CYCLES = WAIT_DEF,
  parameter logic [AW-1:0] ROM_BASE = AW'(16'hE000)
) (
  input  logic          CLK,
  input  logic          R,
  input  logic          REQ,
  input  logic          WE,
  input  logic [AW-1:0] ADDR,
  input  logic [DW-1:0] DIN,
  output logic [DW-1:0] DOUT,
  output logic          RDY,
  output logic          ERR,
  output logic [AW-1:0] sADDR,
  output logic [DW-1:0] sDQ_O,
  input  logic [DW-1:0] sDQ_I,
  output logic          sDQ_OE,
  output logic          sCEN,
  output logic          sOEN,
  output logic          sWEN
);
  localparam int WEFF = wait_eff(WAIT_CYCLES);
  localparam int WW = wait_w(WAIT_CYCLES);
`ifdef MEM_ROM_PROTECT_EN
  localparam logic PROT = 1'b1;
`else
  localparam logic PROT = 1'b0;
`endif
  state_t state_q;
  logic we_q, blk_q, rdy_q, err_q, oe_q, cen_q, oen_q, wen_q, zero, blk;
  logic [DW-1:0] dout_q, wd_q;
  logic [AW-1:0] addr_q;
  assign blk = PROT & WE & (ADDR >= ROM_BASE);
  mem_wait_cnt #(.W(WW)) u_cnt (
    .CLK(CLK),
    .R(R),
    .load(state_q == SETUP),
    .value(WW'(WEFF)),
    .zero(zero)
  );
  // access sequencer with registered SRAM strobes and CPU handshake
  always_ff @(posedge CLK)
    if (R) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      blk_q <= 1'b0;
      dout_q <= '0;
      rdy_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      wd_q <= '0;
      oe_q <= 1'b0;
      cen_q <= 1'b1;
      oen_q <= 1'b1;
      wen_q <= 1'b1;
    end else
      case (state_q)
        IDLE: if (REQ) begin
          state_q <= SETUP;
          we_q <= WE;
          blk_q <= blk;
          addr_q <= ADDR;
          wd_q <= DIN;
          cen_q <= 1'b0;
          oe_q <= WE & ~blk;
        end
        SETUP: begin
          state_q <= ACCESS;
          oen_q <= we_q;
          wen_q <= ~we_q | blk_q;
        end
        ACCESS: if (zero) begin
          state_q <= DONE;
          oen_q <= 1'b1;
          wen_q <= 1'b1;
          rdy_q <= 1'b1;
          err_q <= blk_q;
          if (!we_q) dout_q <= sDQ_I;
        end
        default: begin
          state_q <= IDLE;
          rdy_q <= 1'b0;
          err_q <= 1'b0;
          cen_q <= 1'b1;
          oe_q <= 1'b0;
        end
      endcase
  assign DOUT = dout_q;
  assign RDY = rdy_q;
  assign ERR = err_q;
  assign sADDR = addr_q;
  assign sDQ_O = wd_q;
  assign sDQ_OE = oe_q;
  assign sCEN = cen_q;
  assign sOEN = oen_q;
  assign sWEN = wen_q;
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: table-driven check of mem_bus_ctrl against an async SRAM model
module tb_mem_bus_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic r, req, we, rdy, err, sdq_oe, scen, soen, swen;
  logic [15:0] addr, saddr;
  logic [7:0] din, dout, sdq_o, sdq_i;
  logic req0, rdy0, err0, sdq_oe0, scen0, soen0, swen0;
  logic [15:0] saddr0;
  logic [7:0] dout0, sdq_o0, sdq_i0;
  logic [7:0] mem [0:65535];
  int tests = 0, fails = 0;
  int cyc = 0, rdy_n = 0, err_n = 0, oen_n = 0, wen_n = 0, oe_n = 0, both_low = 0;
  mem_bus_ctrl dut (
    .CLK(clk), .R(r), .REQ(req), .WE(we), .ADDR(addr), .DIN(din), .DOUT(dout), .RDY(rdy), .ERR(err),
    .sADDR(saddr), .sDQ_O(sdq_o), .sDQ_I(sdq_i), .sDQ_OE(sdq_oe), .sCEN(scen), .sOEN(soen), .sWEN(swen)
  );
  mem_bus_ctrl #(.WAIT_CYCLES(0)) dut0 (
    .CLK(clk), .R(r), .REQ(req0), .WE(1'b0), .ADDR(16'h0042), .DIN(8'h00), .DOUT(dout0), .RDY(rdy0), .ERR(err0),
    .sADDR(saddr0), .sDQ_O(sdq_o0), .sDQ_I(sdq_i0), .sDQ_OE(sdq_oe0), .sCEN(scen0), .sOEN(soen0), .sWEN(swen0)
  );
  assign sdq_i = (!scen && !soen) ? mem[saddr] : 8'hEE;
  assign sdq_i0 = (!scen0 && !soen0) ? 8'h5A : 8'hEE;
  initial begin
    logic wl = 1'b0;
    logic [15:0] wa = '0;
    logic [7:0] wd = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h1234] = 8'hA5;
    mem[16'hFFFF] = 8'h5E;
    mem[16'hE000] = 8'h11;
    mem[16'h0300] = 8'h42;
    forever begin
      @(negedge clk);
      cyc++;
      if (wl && swen && !scen) mem[wa] = wd;
      wl = !swen;
      if (!swen) begin
        wa = saddr;
        wd = sdq_o;
      end
      if (!soen) oen_n++;
      if (!swen) wen_n++;
      if (!soen && !swen) both_low++;
      if (sdq_oe) oe_n++;
      if (rdy) rdy_n++;
      if (err) err_n++;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic access(input logic w, input logic [15:0] a, input logic [7:0] d, output int lat);
    lat = -1;
    @(negedge clk);
    req = 1'b1;
    we = w;
    addr = a;
    din = d;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        we = ~w;
        addr = ~a;
        din = ~d;
      end
      if (rdy && lat < 0) begin
        lat = k;
        req = 1'b0;
      end
    end
    req = 1'b0;
  endtask
  typedef struct {
    logic we;
    logic [15:0] addr;
    logic [7:0] din;
    int lat, oen, wen, oe;
    logic [7:0] dout;
    int err;
    logic [7:0] mem;
  } vec_t;
  vec_t v [8];
  initial begin
    int lat, s_rdy, s_err, s_oen, s_wen, s_oe, first, second, n;
    logic idle_cen;
    v[0] = '{1'b0, 16'h1234, 8'h00, 4, 2, 0, 0, 8'hA5, 0, 8'hA5};
    v[1] = '{1'b1, 16'h0200, 8'h3C, 4, 0, 2, 4, 8'hA5, 0, 8'h3C};
    v[2] = '{1'b0, 16'h0200, 8'h00, 4, 2, 0, 0, 8'h3C, 0, 8'h3C};
    v[3] = '{1'b0, 16'hFFFF, 8'h00, 4, 2, 0, 0, 8'h5E, 0, 8'h5E};
`ifdef MEM_ROM_PROTECT_EN
    v[4] = '{1'b1, 16'hE000, 8'hFF, 4, 0, 0, 0, 8'h5E, 1, 8'h11};
    v[6] = '{1'b0, 16'hE000, 8'h00, 4, 2, 0, 0, 8'h11, 0, 8'h11};
`else
    v[4] = '{1'b1, 16'hE000, 8'hFF, 4, 0, 2, 4, 8'h5E, 0, 8'hFF};
    v[6] = '{1'b0, 16'hE000, 8'h00, 4, 2, 0, 0, 8'hFF, 0, 8'hFF};
`endif
    v[5] = '{1'b1, 16'hDFFF, 8'h77, 4, 0, 2, 4, 8'h5E, 0, 8'h77};
    v[7] = '{1'b0, 16'hDFFF, 8'h00, 4, 2, 0, 0, 8'h77, 0, 8'h77};
    r = 1'b1;
    req = 1'b0;
    we = 1'b0;
    addr = '0;
    din = '0;
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst DOUT", dout, 0);
    chk("rst RDY/ERR", {rdy, err}, 0);
    chk("rst sADDR", saddr, 0);
    chk("rst sDQ_O", sdq_o, 0);
    chk("rst strobes", {sdq_oe, scen, soen, swen}, 4'b0111);
    chk("rst dut0 strobes", {rdy0, sdq_oe0, scen0, soen0, swen0}, 5'b00111);
    r = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_rdy = rdy_n;
      s_err = err_n;
      s_oen = oen_n;
      s_wen = wen_n;
      s_oe = oe_n;
      access(v[i].we, v[i].addr, v[i].din, lat);
      chk($sformatf("v%0d rdy latency", i), lat, v[i].lat);
      chk($sformatf("v%0d rdy pulses", i), rdy_n - s_rdy, 1);
      chk($sformatf("v%0d sOEN low cycles", i), oen_n - s_oen, v[i].oen);
      chk($sformatf("v%0d sWEN low cycles", i), wen_n - s_wen, v[i].wen);
      chk($sformatf("v%0d sDQ_OE cycles", i), oe_n - s_oe, v[i].oe);
      chk($sformatf("v%0d DOUT", i), dout, v[i].dout);
      chk($sformatf("v%0d ERR pulses", i), err_n - s_err, v[i].err);
      chk($sformatf("v%0d memory", i), mem[v[i].addr], v[i].mem);
    end
    s_rdy = rdy_n;
    first = -1;
    second = -1;
    idle_cen = 1'b0;
    @(negedge clk);
    req = 1'b1;
    we = 1'b0;
    addr = 16'h1234;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 5) idle_cen = scen;
      if (rdy) begin
        if (first < 0) first = k;
        else if (second < 0) begin
          second = k;
          req = 1'b0;
        end
      end
    end
    req = 1'b0;
    chk("b2b first rdy", first, 4);
    chk("b2b second rdy", second, 9);
    chk("b2b idle sCEN", idle_cen, 1);
    chk("b2b rdy pulses", rdy_n - s_rdy, 2);
    chk("b2b DOUT", dout, 8'hA5);
    s_rdy = rdy_n;
    @(negedge clk);
    req = 1'b1;
    we = 1'b1;
    addr = 16'h0300;
    din = 8'h99;
    repeat (2) @(negedge clk);
    chk("abort sWEN in access", swen, 0);
    r = 1'b1;
    @(negedge clk);
    chk("abort strobes", {sdq_oe, scen, soen, swen}, 4'b0111);
    chk("abort RDY", rdy, 0);
    chk("abort DOUT", dout, 0);
    r = 1'b0;
    req = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort rdy pulses", rdy_n - s_rdy, 0);
    chk("abort memory", mem[16'h0300], 8'h42);
    lat = -1;
    n = 0;
    @(negedge clk);
    req0 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (!soen0) n++;
      if (rdy0 && lat < 0) begin
        lat = k;
        req0 = 1'b0;
      end
    end
    req0 = 1'b0;
    chk("wait0 rdy latency", lat, 3);
    chk("wait0 sOEN low cycles", n, 1);
    chk("wait0 DOUT", dout0, 8'h5A);
    chk("sOEN/sWEN overlap", both_low, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
